// File: rtl/mon_link_pkg.sv
// Shared definitions for the monitor serial link (transmit and receive paths):
// frame width, FSM state encoding and line levels.
package mon_link_pkg;

    localparam int MON_FRAME_W = 40;

    // Line level driven during the start bit and while the link is idle.
    localparam logic MON_START_LVL = 1'b1;
    localparam logic MON_IDLE_LVL  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        GAP
    } mon_state_e;

endpackage

// File: rtl/mon_bit_timer.sv
// Bit-time pacer for the monitor link: a down-counter reloaded with
// CLKS_PER_BIT-1, asserting tick in the last mon_clk cycle of each bit.
module mon_bit_timer
    import mon_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    logic [CNT_W-1:0] cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(CLKS_PER_BIT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/mon_sender.sv
// Monitor link transmitter: accepts frames over valid/ready into a one-entry
// holding register and serializes them MSB first onto from_mon as
// start bit, payload, optional parity bit, then an idle-low gap.
// Optional parity bit enabled by defining MON_SENDER_PARITY_EN.
module mon_sender
    import mon_link_pkg::*;
#(
    parameter int DATA_WIDTH   = MON_FRAME_W,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_CYCLES   = 8
) (
    input  logic                  mon_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  from_mon,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BIT_W   = $clog2(DATA_WIDTH + 1);
    localparam int CYC_MAX = (CLKS_PER_BIT > GAP_CYCLES) ? CLKS_PER_BIT : GAP_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    mon_state_e            state;
    mon_state_e            state_nxt;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [DATA_WIDTH-1:0] shift;
    logic [BIT_W-1:0]      bit_cnt;
    logic [CYC_W-1:0]      gap_cnt;
    logic                  tick;
    logic                  tmr_load;
    logic                  accept;
    logic                  load_shift;
    logic                  shift_en;
    logic                  last_bit;
    logic                  gap_load;
    logic                  gap_end;
    logic                  line_lvl;
`ifdef MON_SENDER_PARITY_EN
    logic                  parity;
`endif

    assign tx_ready = ~hold_full;
    assign accept   = tx_valid & tx_ready;
    assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign busy     = (state != IDLE) | hold_full;

    // Keep the timer primed while idle so START begins with a full bit time;
    // every tick reloads it for the following bit.
    assign tmr_load = (state == IDLE) | tick;

    mon_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (mon_clk),
        .reset(reset),
        .load (tmr_load),
        .tick (tick)
    );

    // FSM state register.
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, control strobes and the line level for the current state.
    always_comb begin
        state_nxt  = state;
        load_shift = 1'b0;
        shift_en   = 1'b0;
        gap_load   = 1'b0;
        gap_end    = 1'b0;
        line_lvl   = MON_IDLE_LVL;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load_shift = 1'b1;
                    state_nxt  = START;
                end
            end
            START: begin
                line_lvl = MON_START_LVL;
                if (tick) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                line_lvl = shift[DATA_WIDTH-1];
                if (tick) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
`ifdef MON_SENDER_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = GAP;
                        gap_load  = 1'b1;
`endif
                    end
                end
            end
`ifdef MON_SENDER_PARITY_EN
            PARITY: begin
                line_lvl = parity;
                if (tick) begin
                    state_nxt = GAP;
                    gap_load  = 1'b1;
                end
            end
`endif
            GAP: begin
                if (gap_cnt == '0) begin
                    gap_end   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Holding register occupancy: a new handshake wins over the IDLE transfer.
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
        end else if (load_shift) begin
            hold_full <= 1'b0;
        end
    end

    // Holding register payload, captured only at the handshake edge.
    always_ff @(posedge mon_clk) begin
        if (accept) begin
            hold_data <= tx_data;
        end
    end

    // Shift register (and parity, when enabled) loaded from the holding register.
    always_ff @(posedge mon_clk) begin
        if (load_shift) begin
            shift <= hold_data;
`ifdef MON_SENDER_PARITY_EN
            parity <= ^hold_data;
`endif
        end else if (shift_en) begin
            shift <= {shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Payload bit counter, restarted for every frame.
    always_ff @(posedge mon_clk) begin
        if (reset || load_shift) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

    // Gap length counter, loaded on entry to GAP.
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (gap_load) begin
            gap_cnt <= CYC_W'(GAP_CYCLES - 1);
        end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Registered outputs; they lag the FSM state by one cycle.
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            from_mon   <= MON_IDLE_LVL;
            frame_done <= 1'b0;
        end else begin
            from_mon   <= line_lvl;
            frame_done <= gap_end;
        end
    end

endmodule

// File: tb/tb_mon_sender.sv
// Directed self-checking bench for mon_sender: a default instance and a
// CLKS_PER_BIT=3 / GAP_CYCLES=1 instance. Honours MON_SENDER_PARITY_EN.
module tb_mon_sender;
    import mon_link_pkg::*;

`ifdef MON_SENDER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam logic PAR_ON = (PB != 0);

    logic        clk;
    logic        reset;
    logic [39:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        from_mon;
    logic        busy;
    logic        frame_done;

    logic [39:0] d3_data;
    logic        d3_valid;
    logic        d3_ready;
    logic        d3_line;
    logic        d3_busy;
    logic        d3_done;

    int total;
    int bad;

    logic fm  [0:159];
    logic fd  [0:159];
    logic rdy [0:159];
    logic bz  [0:159];

    mon_sender dut (
        .mon_clk   (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .from_mon  (from_mon),
        .busy      (busy),
        .frame_done(frame_done)
    );

    mon_sender #(
        .DATA_WIDTH  (40),
        .CLKS_PER_BIT(3),
        .GAP_CYCLES  (1)
    ) dut3 (
        .mon_clk   (clk),
        .reset     (reset),
        .tx_data   (d3_data),
        .tx_valid  (d3_valid),
        .tx_ready  (d3_ready),
        .from_mon  (d3_line),
        .busy      (d3_busy),
        .frame_done(d3_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap_a(input int k);
        fm[k]  = from_mon;
        fd[k]  = frame_done;
        rdy[k] = tx_ready;
        bz[k]  = busy;
    endtask

    task automatic snap_b(input int k);
        fm[k]  = d3_line;
        fd[k]  = d3_done;
        rdy[k] = d3_ready;
        bz[k]  = d3_busy;
    endtask

    task automatic cap_a(input int from_k, input int to_k);
        for (int k = from_k; k <= to_k; k++) begin
            tick();
            snap_a(k);
        end
    endtask

    task automatic cap_b(input int from_k, input int to_k);
        for (int k = from_k; k <= to_k; k++) begin
            tick();
            snap_b(k);
        end
    endtask

    // One frame on the default instance; index k is the sample after edge Ek,
    // E0 being the handshake edge. par is the hand-computed even parity.
    task automatic check_single(input string nm, input logic [39:0] f, input logic par);
        int pulses;
        tx_data  = f;
        tx_valid = 1'b1;
        tick();
        snap_a(0);
        tx_valid = 1'b0;
        tx_data  = ~f;
        cap_a(1, 60);
        chk({nm, "_rdy_low"}, 40'(rdy[0]), 40'd0);
        chk({nm, "_busy"}, 40'(bz[0]), 40'd1);
        chk({nm, "_lat_e1"}, 40'(fm[1]), 40'd0);
        chk({nm, "_start"}, 40'(fm[2]), 40'd1);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("%s_bit%0d", nm, i), 40'(fm[3+i]), 40'(f[39-i]));
        end
        chk({nm, "_par_or_gap"}, 40'(fm[43]), 40'(PAR_ON ? par : 1'b0));
        for (int g = 0; g < 8; g++) begin
            chk($sformatf("%s_gap%0d", nm, g), 40'(fm[43+PB+g]), 40'd0);
        end
        chk({nm, "_done_early"}, 40'(fd[49+PB]), 40'd0);
        chk({nm, "_done"}, 40'(fd[50+PB]), 40'd1);
        chk({nm, "_done_after"}, 40'(fd[51+PB]), 40'd0);
        chk({nm, "_busy_gap"}, 40'(bz[49+PB]), 40'd1);
        chk({nm, "_busy_end"}, 40'(bz[50+PB]), 40'd0);
        chk({nm, "_rdy_end"}, 40'(rdy[51+PB]), 40'd1);
        pulses = 0;
        for (int k = 0; k <= 60; k++) pulses += int'(fd[k]);
        chk({nm, "_pulses"}, 40'(pulses), 40'd1);
    endtask

    initial begin
        int p;
        int ones;
        int g3;
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        d3_data  = '0;
        d3_valid = 1'b0;

        // Reset, then a quiet idle period.
        tick();
        tick();
        reset = 1'b0;
        chk("rst_from_mon", 40'(from_mon), 40'd0);
        chk("rst_tx_ready", 40'(tx_ready), 40'd1);
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_frame_done", 40'(frame_done), 40'd0);
        for (int k = 0; k < 50; k++) begin
            tick();
            chk($sformatf("idle_c%0d", k), 40'({from_mon, tx_ready, busy, frame_done}), 40'b0100);
        end

        // Single frames: A5_0F_C3_81_7E (20 ones, parity 0) and 07 (parity 1).
        check_single("fa", 40'hA5_0F_C3_81_7E, 1'b0);
        check_single("f7", 40'h00_00_00_00_07, 1'b1);

        // Back-to-back: 01 then FF.., tx_valid held until the second is accepted.
        tx_data  = 40'h00_00_00_00_01;
        tx_valid = 1'b1;
        tick();
        snap_a(0);
        chk("bb_rdy_e0", 40'(rdy[0]), 40'd0);
        tick();
        snap_a(1);
        chk("bb_rdy_e1", 40'(tx_ready), 40'd1);
        tx_data = 40'hFF_FF_FF_FF_FF;
        tick();
        snap_a(2);
        tx_valid = 1'b0;
        tx_data  = '0;
        cap_a(3, 110);
        p = 50 + PB;
        chk("bb_start1", 40'(fm[2]), 40'd1);
        for (int i = 0; i < 39; i++) begin
            chk($sformatf("bb_f1_bit%0d", i), 40'(fm[3+i]), 40'd0);
        end
        chk("bb_f1_bit39", 40'(fm[42]), 40'd1);
        chk("bb_f1_par_or_gap", 40'(fm[43]), 40'(PAR_ON));
        chk("bb_f1_done", 40'(fd[50+PB]), 40'd1);
        chk("bb_idle_between", 40'(fm[51+PB]), 40'd0);
        chk("bb_pre_start2", 40'(fm[1+p]), 40'd0);
        chk("bb_start2", 40'(fm[2+p]), 40'd1);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("bb_f2_bit%0d", i), 40'(fm[3+p+i]), 40'd1);
        end
        chk("bb_f2_par_or_gap", 40'(fm[43+p]), 40'd0);
        chk("bb_f2_done", 40'(fd[50+PB+p]), 40'd1);
        chk("bb_rdy_held_a", 40'(rdy[3]), 40'd0);
        chk("bb_rdy_held_b", 40'(rdy[50+PB]), 40'd0);
        chk("bb_rdy_free", 40'(rdy[51+PB]), 40'd1);
        ones = 0;
        for (int k = 0; k <= 110; k++) ones += int'(fd[k]);
        chk("bb_pulses", 40'(ones), 40'd2);

        // Reset during payload bit 20 with a second frame held.
        tx_data  = 40'hFF_FF_FF_FF_FF;
        tx_valid = 1'b1;
        tick();
        tx_data = 40'h12_34_56_78_9A;
        tick();
        tick();
        tx_valid = 1'b0;
        chk("rab_held", 40'(tx_ready), 40'd0);
        for (int k = 3; k <= 22; k++) tick();
        chk("rab_bit19", 40'(from_mon), 40'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rab_from_mon", 40'(from_mon), 40'd0);
        chk("rab_tx_ready", 40'(tx_ready), 40'd1);
        chk("rab_busy", 40'(busy), 40'd0);
        chk("rab_frame_done", 40'(frame_done), 40'd0);
        for (int k = 0; k < 60; k++) begin
            tick();
            chk($sformatf("rab_quiet%0d", k), 40'({from_mon, frame_done, busy}), 40'd0);
        end
        check_single("rnew", 40'h3C_00_FF_00_C3, 1'b0);

        // CLKS_PER_BIT=3, GAP_CYCLES=1 instance, payload 80_00_00_00_00.
        d3_data  = 40'h80_00_00_00_00;
        d3_valid = 1'b1;
        tick();
        snap_b(0);
        d3_valid = 1'b0;
        d3_data  = '0;
        cap_b(1, 140);
        chk("b_lat_e1", 40'(fm[1]), 40'd0);
        for (int k = 2; k <= 4; k++) chk($sformatf("b_start%0d", k), 40'(fm[k]), 40'd1);
        for (int k = 5; k <= 7; k++) chk($sformatf("b_msb%0d", k), 40'(fm[k]), 40'd1);
        ones = 0;
        for (int k = 8; k <= 124; k++) ones += int'(fm[k]);
        chk("b_data_low", 40'(ones), 40'd0);
        for (int k = 125; k <= 127; k++) chk($sformatf("b_par_or_gap%0d", k), 40'(fm[k]), 40'(PAR_ON));
        g3 = 125 + 3 * PB;
        chk("b_gap", 40'(fm[g3]), 40'd0);
        chk("b_done_early", 40'(fd[g3-1]), 40'd0);
        chk("b_done", 40'(fd[g3]), 40'd1);
        chk("b_done_after", 40'(fd[g3+1]), 40'd0);
        chk("b_busy_gap", 40'(bz[g3-1]), 40'd1);
        chk("b_busy_end", 40'(bz[g3]), 40'd0);
        ones = 0;
        for (int k = 0; k <= 140; k++) ones += int'(fd[k]);
        chk("b_pulses", 40'(ones), 40'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
